// File: rtl/cla_adder_if.sv
// cla_adder_if: operand/result bundle for cla_adder.
// Ovf is present only when CLA_OVERFLOW_EN is defined.
interface cla_adder_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             iniC;
    logic [WIDTH-1:0] Sum;
    logic             Carry;
    logic             out_valid;
`ifdef CLA_OVERFLOW_EN
    logic             Ovf;
`endif
    modport master (
        output in_valid, A, B, iniC,
`ifdef CLA_OVERFLOW_EN
        input Ovf,
`endif
        input Sum, Carry, out_valid
    );
    modport slave (
        input in_valid, A, B, iniC,
`ifdef CLA_OVERFLOW_EN
        output Ovf,
`endif
        output Sum, Carry, out_valid
    );
endinterface

// File: rtl/cla_adder.sv
// cla_adder: registered Kogge-Stone adder, {Carry,Sum} = A + B + iniC, one-cycle latency.
// Defining CLA_OVERFLOW_EN adds a registered signed-overflow flag Ovf.
module cla_adder #(parameter int WIDTH = 16) (
    input  logic clk,
    input  logic rst_n,
    cla_adder_if.slave bus
);
    localparam int LOG = $clog2(WIDTH);
    // Node j of each level holds bit j-1; node 0 is the carry-in as a generate term.
    logic [LOG:0][WIDTH:0] gt, pt;
    logic [WIDTH-1:0]      c;
    logic                  cout;
    always_comb begin
        gt = '0;
        pt = '0;
        gt[0] = {bus.A & bus.B, bus.iniC};
        pt[0] = {bus.A ^ bus.B, 1'b0};
        for (int k = 0; k < LOG; k++) begin
            for (int j = 0; j <= WIDTH; j++) begin
                if (j >= (1 << k)) begin
                    gt[k+1][j] = gt[k][j] | (pt[k][j] & gt[k][j-(1<<k)]);
                    pt[k+1][j] = pt[k][j] & pt[k][j-(1<<k)];
                end else begin
                    gt[k+1][j] = gt[k][j];
                    pt[k+1][j] = pt[k][j];
                end
            end
        end
    end
    assign c    = gt[LOG][WIDTH-1:0];
    // The MSB node spans bits WIDTH-1..0; one more cell folds in the carry-in.
    assign cout = gt[LOG][WIDTH] | (pt[LOG][WIDTH] & gt[LOG][0]);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.Sum       <= '0;
            bus.Carry     <= 1'b0;
            bus.out_valid <= 1'b0;
`ifdef CLA_OVERFLOW_EN
            bus.Ovf       <= 1'b0;
`endif
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.Sum   <= pt[0][WIDTH:1] ^ c;
                bus.Carry <= cout;
`ifdef CLA_OVERFLOW_EN
                bus.Ovf   <= c[WIDTH-1] ^ cout;
`endif
            end
        end
    end
endmodule

// File: tb/tb_cla_adder.sv
// tb_cla_adder: directed table, hand sequences and random scoreboard for cla_adder.
module tb_cla_adder;
    localparam int W = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    cla_adder_if #(.WIDTH(W)) bus ();
    cla_adder #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } res_t;
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        res_t         r;
    } vec_t;

    res_t q[$];
    int   n_vec = 0;
    int   n_fail = 0;
    logic exp_ov = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        logic [W:0] t;
        res_t r;
        t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        r.s = t[W-1:0];
        r.c = t[W];
        r.o = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        return r;
    endfunction

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic v, input res_t e);
        @(negedge clk);
        bus.A = a;
        bus.B = b;
        bus.iniC = ci;
        bus.in_valid = v;
        exp_ov = v;
        if (v) q.push_back(e);
    endtask

    always @(posedge clk) begin
        res_t e;
        #1;
        if (rst_n) begin
            check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_ov});
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("sum", {16'd0, bus.Sum}, {16'd0, e.s});
                    check("carry", {31'd0, bus.Carry}, {31'd0, e.c});
`ifdef CLA_OVERFLOW_EN
                    check("ovf", {31'd0, bus.Ovf}, {31'd0, e.o});
`else
                    if (e.o === 1'bx) check("ovf_model", 32'd1, 32'd0);
`endif
                end
            end
        end
    end

    initial begin
        vec_t tbl[9];
        int   nv;
        logic [W-1:0] ra, rb;
        logic         rc, rv;
        tbl[0] = '{16'd10000, 16'd20000, 1'b1, '{16'd30001, 1'b0, 1'b0}};
        tbl[1] = '{16'd45000, 16'd4,     1'b1, '{16'd45005, 1'b0, 1'b0}};
        tbl[2] = '{16'd1,     16'd999,   1'b1, '{16'd1001,  1'b0, 1'b0}};
        tbl[3] = '{16'hFFFF,  16'h0000,  1'b1, '{16'h0000,  1'b1, 1'b0}};
        tbl[4] = '{16'hFFFF,  16'hFFFF,  1'b1, '{16'hFFFF,  1'b1, 1'b0}};
        tbl[5] = '{16'h7FFF,  16'h0001,  1'b0, '{16'h8000,  1'b0, 1'b1}};
        tbl[6] = '{16'h8000,  16'h8000,  1'b0, '{16'h0000,  1'b1, 1'b1}};
        tbl[7] = '{16'h0000,  16'h0000,  1'b0, '{16'h0000,  1'b0, 1'b0}};
        tbl[8] = '{16'hAAAA,  16'h5555,  1'b1, '{16'h0000,  1'b1, 1'b0}};
        bus.A = '0;
        bus.B = '0;
        bus.iniC = 1'b0;
        bus.in_valid = 1'b0;
        #2;
        check("reset_sum", {16'd0, bus.Sum}, 32'd0);
        check("reset_carry", {31'd0, bus.Carry}, 32'd0);
        check("reset_valid", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) drive(tbl[i].a, tbl[i].b, tbl[i].ci, 1'b1, tbl[i].r);
        // Hold: idle edge with new operands must not disturb the last result.
        drive(16'h1234, 16'h0001, 1'b0, 1'b1, '{16'h1235, 1'b0, 1'b0});
        drive(16'h5555, 16'hAAAA, 1'b1, 1'b0, '0);
        @(posedge clk);
        #2;
        check("hold_sum", {16'd0, bus.Sum}, 32'h1235);
        check("hold_carry", {31'd0, bus.Carry}, 32'd0);
        check("hold_valid", {31'd0, bus.out_valid}, 32'd0);
        // Asynchronous reset while a fresh result is on the outputs.
        drive(16'h4321, 16'h1111, 1'b1, 1'b1, '{16'h5433, 1'b0, 1'b0});
        @(posedge clk);
        #2;
        check("pre_reset_valid", {31'd0, bus.out_valid}, 32'd1);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        exp_ov = 1'b0;
        #1;
        check("async_rst_sum", {16'd0, bus.Sum}, 32'd0);
        check("async_rst_carry", {31'd0, bus.Carry}, 32'd0);
        check("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        while (nv < 10000) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            rv = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) ra = 16'hFFFF;
            drive(ra, rb, rc, rv, model(ra, rb, rc));
            if (rv) nv++;
        end
        drive('0, '0, 1'b0, 1'b0, '0);
        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/cla_adder.md
Name: cla_adder

Overview:
- 16-bit carry-lookahead adder computing A + B + iniC.
- Carries are resolved by recursive doubling, i.e. a log2(WIDTH)-level parallel-prefix (Kogge-Stone) tree over generate/propagate pairs.
- Result is registered in the datapath clock domain: one-cycle latency, with a valid flag.
- Used as the arithmetic core wherever a fast wide add is needed.

Parameters:
- WIDTH, 16, operand/sum width; must be a power of two ≥ 2; prefix depth = log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  A/B/iniC valid this cycle.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- iniC  input  1  carry-in.
- Sum  output  WIDTH  registered sum bits.
- Carry  output  1  registered carry-out of MSB.
- out_valid  output  1  Sum/Carry hold a fresh result.

Behaviour:
- Reset: rst_n low forces Sum=0, Carry=0, out_valid=0 immediately, without waiting for clk. Outputs hold these values while reset is asserted. Reset mid-operation discards any in-flight result.
- Per-bit signals: g[i]=A[i]&B[i], p[i]=A[i]^B[i].
- Carry-in handling: iniC is folded in as a position -1 generate term (G[-1]=iniC, P[-1]=0), so the carry into bit i equals the group generate over [i-1 : -1].
- Prefix tree: levels k=0..log2(WIDTH)-1 with span d=2^k.
  - (G,P)[i] ← (G[i] | P[i]&G[i-d], P[i]&P[i-d]) when i-d ≥ -1.
  - Otherwise the pair passes through unchanged.
  - Each level is a distinct combinational stage; no ripple chain.
- Outputs: Sum[i]=p[i]^c[i], with c[0]=iniC. Carry = final group generate at bit WIDTH-1 (carry out of the full WIDTH+1-bit add).
- Arithmetic: {Carry,Sum} = A + B + iniC exactly, modulo 2^(WIDTH+1).
  - No saturation.
  - Wrap-around: 0xFFFF+0x0000+1 gives Sum=0x0000, Carry=1.
- Latency: inputs are sampled on a rising clk edge with in_valid=1; Sum/Carry update on that same edge, with out_valid=1.
- in_valid=0 on an edge: Sum/Carry hold their previous values and out_valid goes 0.
- Throughput: one add per cycle; back-to-back in_valid is supported with no bubbles.
- No backpressure: the consumer must take each result the cycle out_valid is high.

Optional Feature:
- Macro CLA_OVERFLOW_EN.
- When defined:
  - Adds output port Ovf (1 bit, registered alongside Sum).
  - Ovf = carry into MSB XOR carry out of MSB, i.e. signed two's-complement overflow.
  - Ovf resets to 0, is updated under the same in_valid rule as Sum, and holds when in_valid=0.
- When not defined: Ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 → Sum=0, Carry=0, out_valid=0 immediately, without waiting for a clk edge.
- A=10000, B=20000, iniC=1, in_valid=1 → next edge Sum=30001, Carry=0, out_valid=1. Then A=45000, B=4, iniC=1 → Sum=45005, Carry=0. Then A=1, B=999, iniC=1 → Sum=1001, Carry=0 (back-to-back, one result per cycle).
- Full carry propagation: A=0xFFFF, B=0x0000, iniC=1 → Sum=0x0000, Carry=1. Then A=0xFFFF, B=0xFFFF, iniC=1 → Sum=0xFFFF, Carry=1.
- Hold: apply A=0x1234, B=0x0001, iniC=0 → Sum=0x1235. Then drive in_valid=0 with different operands → Sum stays 0x1235, Carry stays 0, out_valid=0.
- Randomized: ≥10k random A/B/iniC vectors checked against {Carry,Sum}=A+B+iniC. With CLA_OVERFLOW_EN defined, additionally check A=0x7FFF, B=0x0001, iniC=0 → Ovf=1, and A=0x8000, B=0x8000, iniC=0 → Sum=0, Carry=1, Ovf=1.
